// File: rtl/alu_pkg.sv
// Shared constants for the sign-magnitude ALU: widths, opcodes and a
// normalisation helper that keeps a zero magnitude positive.
package alu_pkg;

  localparam int IN_W  = 3;
  localparam int MAG_W = IN_W - 1;
  localparam int R_W   = 2 * IN_W - 1;
  localparam int RM_W  = R_W - 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // Pack sign and magnitude, forcing the sign to 0 when the magnitude is 0.
  function automatic logic [R_W-1:0] sm_pack(input logic sign, input logic [RM_W-1:0] mag);
    logic sign_n;
    sign_n = sign & (mag != {RM_W{1'b0}});
    return {sign_n, mag};
  endfunction

endpackage

// File: rtl/alu_sm_mag_div.sv
// Combinational restoring divider on unsigned magnitudes. The quotient is
// forced to zero when the divisor is zero; b_zero_o reports that case.
module sm_mag_div
  import alu_pkg::*;
(
  input  logic [MAG_W-1:0] a_i,
  input  logic [MAG_W-1:0] b_i,
  output logic [MAG_W-1:0] q_o,
  output logic             b_zero_o
);

  logic [MAG_W:0]   rem_s;
  logic [MAG_W+1:0] trial_s;
  logic [MAG_W-1:0] quot_s;

  // Restoring division: shift in one dividend bit per step, subtract if it fits.
  always_comb begin
    rem_s    = {(MAG_W+1){1'b0}};
    trial_s  = {(MAG_W+2){1'b0}};
    quot_s   = {MAG_W{1'b0}};
    b_zero_o = (b_i == {MAG_W{1'b0}});
    for (int i = MAG_W - 1; i >= 0; i--) begin
      rem_s   = {rem_s[MAG_W-1:0], a_i[i]};
      trial_s = {1'b0, rem_s} - {2'b00, b_i};
      if (trial_s[MAG_W+1] == 1'b0) begin
        rem_s     = trial_s[MAG_W:0];
        quot_s[i] = 1'b1;
      end else begin
        quot_s[i] = 1'b0;
      end
    end
    if (b_zero_o) begin
      q_o = {MAG_W{1'b0}};
    end else begin
      q_o = quot_s;
    end
  end

endmodule

// File: rtl/alu.sv
// Registered sign-magnitude ALU: ADD/SUB/MUL/DIV on 3-bit operands with a
// 5-bit sign-magnitude result and sign/zero/divide-by-zero flags, one cycle
// of latency.
module alu
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IN_W-1:0] A,
  input  logic [IN_W-1:0] B,
  input  logic [1:0]      S,
  output logic [R_W-1:0]  R,
  output logic            SF,
  output logic            ZF,
  output logic            DZF
);

  logic [MAG_W-1:0] a_mag_s, b_mag_s, q_mag_s;
  logic             a_sgn_s, b_sgn_s, b_eff_sgn_s, b_zero_s;
  logic [RM_W-1:0]  addsub_mag_s, mul_mag_s, res_mag_s;
  logic             addsub_sgn_s, res_sgn_s;

  logic [R_W-1:0]   r_d, r_q;
  logic             sf_d, sf_q, zf_d, zf_q, dzf_d, dzf_q;

  // Magnitude divider shared by the DIV path.
  sm_mag_div u_div (
    .a_i      (a_mag_s),
    .b_i      (b_mag_s),
    .q_o      (q_mag_s),
    .b_zero_o (b_zero_s)
  );

  // Split operands; negative zero loses its sign so it behaves as +0.
  always_comb begin
    a_mag_s     = A[MAG_W-1:0];
    b_mag_s     = B[MAG_W-1:0];
    a_sgn_s     = A[IN_W-1] & (a_mag_s != {MAG_W{1'b0}});
    b_sgn_s     = B[IN_W-1] & (b_mag_s != {MAG_W{1'b0}});
    if (S == OP_SUB) begin
      b_eff_sgn_s = ~b_sgn_s;
    end else begin
      b_eff_sgn_s = b_sgn_s;
    end
  end

  // Signed add of magnitudes: same sign adds, else larger minus smaller.
  always_comb begin
    if (a_sgn_s == b_eff_sgn_s) begin
      addsub_mag_s = {2'b00, a_mag_s} + {2'b00, b_mag_s};
      addsub_sgn_s = a_sgn_s;
    end else if (a_mag_s >= b_mag_s) begin
      addsub_mag_s = {2'b00, a_mag_s} - {2'b00, b_mag_s};
      addsub_sgn_s = a_sgn_s;
    end else begin
      addsub_mag_s = {2'b00, b_mag_s} - {2'b00, a_mag_s};
      addsub_sgn_s = b_eff_sgn_s;
    end
    mul_mag_s = {2'b00, a_mag_s} * {2'b00, b_mag_s};
  end

  // Opcode mux and flag generation feeding the output register.
  always_comb begin
    res_mag_s = {RM_W{1'b0}};
    res_sgn_s = 1'b0;
    dzf_d     = 1'b0;
    case (S)
      OP_ADD, OP_SUB: begin
        res_mag_s = addsub_mag_s;
        res_sgn_s = addsub_sgn_s;
      end
      OP_MUL: begin
        res_mag_s = mul_mag_s;
        res_sgn_s = a_sgn_s ^ b_sgn_s;
      end
      OP_DIV: begin
        res_mag_s = {2'b00, q_mag_s};
        res_sgn_s = a_sgn_s ^ b_sgn_s;
        dzf_d     = b_zero_s;
      end
      default: begin
        res_mag_s = {RM_W{1'b0}};
        res_sgn_s = 1'b0;
        dzf_d     = 1'b0;
      end
    endcase
    r_d  = sm_pack(res_sgn_s, res_mag_s);
    sf_d = r_d[R_W-1];
    zf_d = (r_d[RM_W-1:0] == {RM_W{1'b0}});
  end

  // Single output register stage; asynchronous clear to all zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= {R_W{1'b0}};
      sf_q  <= 1'b0;
      zf_q  <= 1'b0;
      dzf_q <= 1'b0;
    end else begin
      r_q   <= r_d;
      sf_q  <= sf_d;
      zf_q  <= zf_d;
      dzf_q <= dzf_d;
    end
  end

  assign R   = r_q;
  assign SF  = sf_q;
  assign ZF  = zf_q;
  assign DZF = dzf_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, reset corner cases and
// an exhaustive sweep against an integer model.
module tb_alu;

  logic       clk;
  logic       rst_n;
  logic [2:0] A, B;
  logic [1:0] S;
  logic [4:0] R;
  logic       SF, ZF, DZF;

  int checks = 0;
  int errors = 0;

  alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .S     (S),
    .R     (R),
    .SF    (SF),
    .ZF    (ZF),
    .DZF   (DZF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] s;
    logic [4:0] r;
    logic       sf;
    logic       zf;
    logic       dzf;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [4:0] r, input logic sf,
                         input logic zf, input logic dzf);
    chk({name, ".R"},   int'(R),   int'(r));
    chk({name, ".SF"},  int'(SF),  int'(sf));
    chk({name, ".ZF"},  int'(ZF),  int'(zf));
    chk({name, ".DZF"}, int'(DZF), int'(dzf));
  endtask

  task automatic apply(input logic [2:0] a, input logic [2:0] b, input logic [1:0] s);
    A = a;
    B = b;
    S = s;
    @(posedge clk);
    #1;
  endtask

  function automatic int sm_val(input logic [2:0] x);
    int m;
    m = int'(x[1:0]);
    return x[2] ? -m : m;
  endfunction

  initial begin
    int va, vb, res, mag;
    logic [4:0] er;
    logic edz;

    vecs[0]  = '{"add_p3_m2",  3'b011, 3'b110, 2'b00, 5'b00001, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{"sub_p3_m2",  3'b011, 3'b110, 2'b01, 5'b00101, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{"sub_zero",   3'b010, 3'b010, 2'b01, 5'b00000, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{"mul_p3_m2",  3'b011, 3'b110, 2'b10, 5'b10110, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{"mul_max",    3'b111, 3'b111, 2'b10, 5'b01001, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{"div_p3_m2",  3'b011, 3'b110, 2'b11, 5'b10001, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{"div_m1_p3",  3'b101, 3'b011, 2'b11, 5'b00000, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{"div_by_0",   3'b010, 3'b000, 2'b11, 5'b00000, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{"add_negz",   3'b100, 3'b100, 2'b00, 5'b00000, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{"div_by_n0",  3'b011, 3'b100, 2'b11, 5'b00000, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{"add_m3_p1",  3'b111, 3'b001, 2'b00, 5'b10010, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{"sub_m3_p3",  3'b111, 3'b011, 2'b01, 5'b10110, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{"add_p3_p3",  3'b011, 3'b011, 2'b00, 5'b00110, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{"mul_n0_m3",  3'b100, 3'b111, 2'b10, 5'b00000, 1'b0, 1'b1, 1'b0};

    // Reset with arbitrary inputs: outputs zero immediately.
    rst_n = 1'b0;
    A = 3'b111; B = 3'b000; S = 2'b11;
    #2;
    chk_all("reset", 5'b00000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("reset_hold", 5'b00000, 1'b0, 1'b0, 1'b0);

    // Release mid-stream: first edge computes from current inputs (DIV by 0).
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("rst_release", 5'b00000, 1'b0, 1'b1, 1'b1);

    // Directed table.
    foreach (vecs[i]) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].s);
      chk_all(vecs[i].name, vecs[i].r, vecs[i].sf, vecs[i].zf, vecs[i].dzf);
    end

    // Asynchronous reset mid-cycle clears a nonzero registered result.
    apply(3'b111, 3'b111, 2'b10);
    chk_all("pre_async", 5'b01001, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 5'b00000, 1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    apply(3'b011, 3'b110, 2'b10);
    chk_all("post_async", 5'b10110, 1'b1, 1'b0, 1'b0);

    // Exhaustive sweep, back-to-back operations, against an integer model.
    for (int s = 0; s < 4; s++) begin
      for (int a = 0; a < 8; a++) begin
        for (int b = 0; b < 8; b++) begin
          va  = sm_val(3'(a));
          vb  = sm_val(3'(b));
          edz = 1'b0;
          case (s)
            0: res = va + vb;
            1: res = va - vb;
            2: res = va * vb;
            default: begin
              if (vb == 0) begin
                res = 0;
                edz = 1'b1;
              end else begin
                res = va / vb;
              end
            end
          endcase
          mag = (res < 0) ? -res : res;
          er  = {(res < 0) ? 1'b1 : 1'b0, 4'(mag)};
          apply(3'(a), 3'(b), 2'(s));
          chk_all($sformatf("sweep_s%0d_a%0d_b%0d", s, a, b), er, er[4], (mag == 0), edz);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
